// File: rtl/mem_stage_access_unit_if.sv
// mem_stage_access_unit_if: data-cache port between the MEM-stage sequencer and the D-cache.
interface mem_stage_access_unit_if;
    logic        dmem_read;
    logic        dmem_write;
    logic [15:0] dmem_address;
    logic [15:0] dmem_wdata;
    logic [1:0]  dmem_byte_enable;
    logic [15:0] dmem_rdata;
    logic        dmem_resp;
    modport master (
        output dmem_read, dmem_write, dmem_address, dmem_wdata, dmem_byte_enable,
        input  dmem_rdata, dmem_resp
    );
    modport slave (
        input  dmem_read, dmem_write, dmem_address, dmem_wdata, dmem_byte_enable,
        output dmem_rdata, dmem_resp
    );
endinterface

// File: rtl/mem_stage_access_unit.sv
// mem_stage_access_unit: MEM-stage sequencer for word/byte loads, stores and LDI/STI indirection.
module mem_stage_access_unit (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           mem_read,
    input  logic                           mem_write,
    input  logic                           is_ldi,
    input  logic                           is_sti,
    input  logic                           is_ldb_stb,
    input  logic [15:0]                    addr,
    input  logic [15:0]                    wdata,
    input  logic [1:0]                     mem_byte_enable,
    input  logic                           ext_stall,
    mem_stage_access_unit_if.master        dmem,
    output logic [15:0]                    mem_rdata,
    output logic                           mem_stall
);
    typedef enum logic [1:0] {IDLE, IND_RD, ACCESS} state_t;
    state_t      state;
    logic [15:0] ptr;
    logic [15:0] rdata_q;
    logic        done;
    logic        req;
    logic        ind;
    logic        in_ind;
    logic        in_acc;
    logic        rd_done;
    logic [15:0] ea;
    logic [15:0] ld_val;
    always_comb begin
        req     = mem_read | mem_write;
        ind     = is_ldi | is_sti;
        in_ind  = state == IND_RD;
        in_acc  = state == ACCESS;
        ea      = ind ? ptr : addr;
        ld_val  = is_ldb_stb ? {8'h00, ea[0] ? dmem.dmem_rdata[15:8] : dmem.dmem_rdata[7:0]} : dmem.dmem_rdata;
        rd_done = in_acc & dmem.dmem_resp & mem_read;
        mem_rdata = rd_done ? ld_val : rdata_q;
        // gated by rst_n so a request held through reset cannot raise a stall
        mem_stall = rst_n & (in_ind | (in_acc & ~dmem.dmem_resp) | (state == IDLE & req & ~done));
        dmem.dmem_read  = in_ind | (in_acc & mem_read);
        dmem.dmem_write = in_acc & mem_write & ~mem_read;
        dmem.dmem_address = in_ind ? {addr[15:1], 1'b0} : in_acc ? {ea[15:1], 1'b0} : 16'h0000;
        dmem.dmem_byte_enable = in_ind ? 2'b11 :
                                in_acc ? (is_ldb_stb ? (ea[0] ? 2'b10 : 2'b01) : mem_byte_enable) : 2'b00;
        dmem.dmem_wdata = in_acc ? (is_ldb_stb ? {wdata[7:0], wdata[7:0]} : wdata) : 16'h0000;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            ptr     <= 16'h0000;
            rdata_q <= 16'h0000;
            done    <= 1'b0;
        end else begin
            case (state)
                IDLE:    if (req & ~done) state <= ind ? IND_RD : ACCESS;
                IND_RD:  if (dmem.dmem_resp) begin
                             ptr   <= dmem.dmem_rdata;
                             state <= ACCESS;
                         end
                ACCESS:  if (dmem.dmem_resp) begin
                             state <= IDLE;
                             if (mem_read) rdata_q <= ld_val;
                         end
                default: state <= IDLE;
            endcase
            // done marks an instruction serviced while EX/MEM is frozen by someone else
            if (in_acc & dmem.dmem_resp & ext_stall) done <= 1'b1;
            else if (~ext_stall & ~mem_stall) done <= 1'b0;
        end
    end
endmodule

// File: tb/tb_mem_stage_access_unit.sv
// tb_mem_stage_access_unit: directed stimulus with a queue-based scoreboard on every cache response.
module tb_mem_stage_access_unit;
    logic        clk = 0;
    logic        rst_n = 0;
    logic        mem_read = 0, mem_write = 0, is_ldi = 0, is_sti = 0, is_ldb_stb = 0, ext_stall = 0;
    logic [15:0] addr = 0, wdata = 0;
    logic [1:0]  mem_byte_enable = 0;
    logic [15:0] mem_rdata;
    logic        mem_stall;
    mem_stage_access_unit_if bus();
    mem_stage_access_unit dut (
        .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
        .is_ldi(is_ldi), .is_sti(is_sti), .is_ldb_stb(is_ldb_stb), .addr(addr), .wdata(wdata),
        .mem_byte_enable(mem_byte_enable), .ext_stall(ext_stall), .dmem(bus),
        .mem_rdata(mem_rdata), .mem_stall(mem_stall)
    );
    always #5 clk = ~clk;
    typedef struct {
        logic        rd, wr, st, cr;
        logic [15:0] a, wd, rv;
        logic [1:0]  be;
    } exp_t;
    exp_t        q[$];
    exp_t        e;
    int          errors = 0, checks = 0, lat = 1, wr_cnt = 0, cache_cnt = 0, s = 0, w0 = 0;
    logic [15:0] mem [logic [15:0]];
    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    task automatic push(input logic rd, input logic wr, input logic st, input logic cr,
                        input logic [15:0] a, input logic [1:0] be, input logic [15:0] wd, input logic [15:0] rv);
        exp_t x;
        x.rd = rd; x.wr = wr; x.st = st; x.cr = cr; x.a = a; x.be = be; x.wd = wd; x.rv = rv;
        q.push_back(x);
    endtask
    task automatic op(input logic rd, input logic wr, input logic ldi, input logic sti, input logic bt,
                      input logic [15:0] a, input logic [15:0] wd, input logic [1:0] be);
        mem_read = rd; mem_write = wr; is_ldi = ldi; is_sti = sti; is_ldb_stb = bt;
        addr = a; wdata = wd; mem_byte_enable = be;
    endtask
    task automatic idle_inputs();
        op(0, 0, 0, 0, 0, 16'h0, 16'h0, 2'b00);
    endtask
    task automatic wait_done(output int stalls);
        stalls = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk); #2;
            if (mem_stall) stalls++;
            if (bus.dmem_resp && !mem_stall) begin
                @(posedge clk); #1;
                return;
            end
        end
        checks++; errors++;
        $display("FAIL timeout: no completion within 60 cycles, required a response");
        @(posedge clk); #1;
    endtask
    // cache model: responds lat cycles after a strobe is seen, one-cycle resp pulse
    initial begin
        bus.dmem_resp = 0; bus.dmem_rdata = 0;
        forever begin
            @(negedge clk);
            if (rst_n && (bus.dmem_read || bus.dmem_write)) begin
                cache_cnt++;
                if (cache_cnt >= lat) begin
                    cache_cnt = 0;
                    bus.dmem_resp = 1;
                    bus.dmem_rdata = mem.exists(bus.dmem_address) ? mem[bus.dmem_address] : 16'h0;
                end
            end else cache_cnt = 0;
            @(posedge clk); #1 bus.dmem_resp = 0;
        end
    end
    always @(posedge clk) if (bus.dmem_write && bus.dmem_resp) wr_cnt++;
    initial begin
        forever begin
            @(negedge clk); #1;
            if (bus.dmem_resp) begin
                if (q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_access: got addr %h, required no access", bus.dmem_address);
                end else begin
                    e = q.pop_front();
                    chk("dmem_read", 16'(bus.dmem_read), 16'(e.rd));
                    chk("dmem_write", 16'(bus.dmem_write), 16'(e.wr));
                    chk("dmem_address", bus.dmem_address, e.a);
                    chk("dmem_byte_enable", 16'(bus.dmem_byte_enable), 16'(e.be));
                    chk("mem_stall_at_resp", 16'(mem_stall), 16'(e.st));
                    if (e.wr) chk("dmem_wdata", bus.dmem_wdata, e.wd);
                    if (e.cr) chk("mem_rdata_resp", mem_rdata, e.rv);
                end
            end
        end
    end
    initial begin
        mem[16'h1004] = 16'hBEEF;
        mem[16'h2000] = 16'h7A55;
        mem[16'h4000] = 16'h5000;
        mem[16'h5000] = 16'h0042;
        mem[16'h7000] = 16'h8000;
        mem[16'h8000] = 16'h1111;
        mem_read = 1;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_mem_stall", 16'(mem_stall), 16'h0);
        chk("reset_dmem_read", 16'(bus.dmem_read), 16'h0);
        chk("reset_mem_rdata", mem_rdata, 16'h0);
        mem_read = 0;
        rst_n = 1;
        @(posedge clk); #1;
        lat = 3;
        push(1, 0, 0, 1, 16'h1004, 2'b11, 16'h0, 16'hBEEF);
        op(1, 0, 0, 0, 0, 16'h1004, 16'h0, 2'b11);
        wait_done(s);
        idle_inputs();
        chk("ldr_stall_cycles", 16'(s), 16'd3);
        @(negedge clk); #1;
        chk("ldr_rdata_hold", mem_rdata, 16'hBEEF);
        @(posedge clk); #1;
        lat = 1;
        push(1, 0, 0, 1, 16'h2000, 2'b10, 16'h0, 16'h007A);
        op(1, 0, 0, 0, 1, 16'h2001, 16'h0, 2'b11);
        wait_done(s);
        push(1, 0, 0, 1, 16'h2000, 2'b01, 16'h0, 16'h0055);
        op(1, 0, 0, 0, 1, 16'h2000, 16'h0, 2'b11);
        wait_done(s);
        w0 = wr_cnt;
        push(0, 1, 0, 0, 16'h3002, 2'b10, 16'hC4C4, 16'h0);
        op(0, 1, 0, 0, 1, 16'h3003, 16'h12C4, 2'b11);
        wait_done(s);
        idle_inputs();
        chk("stb_write_count", 16'(wr_cnt - w0), 16'd1);
        lat = 2;
        w0 = wr_cnt;
        push(1, 0, 1, 0, 16'h4000, 2'b11, 16'h0, 16'h0);
        push(1, 0, 0, 1, 16'h5000, 2'b11, 16'h0, 16'h0042);
        op(1, 0, 1, 0, 0, 16'h4000, 16'h0, 2'b11);
        wait_done(s);
        idle_inputs();
        chk("ldi_write_count", 16'(wr_cnt - w0), 16'd0);
        w0 = wr_cnt;
        push(1, 0, 1, 0, 16'h4000, 2'b11, 16'h0, 16'h0);
        push(0, 1, 0, 0, 16'h5000, 2'b11, 16'h5A5A, 16'h0);
        op(0, 1, 0, 1, 0, 16'h4000, 16'h5A5A, 2'b11);
        wait_done(s);
        idle_inputs();
        chk("sti_write_count", 16'(wr_cnt - w0), 16'd1);
        lat = 1;
        w0 = wr_cnt;
        push(0, 1, 0, 0, 16'h6000, 2'b11, 16'hABCD, 16'h0);
        op(0, 1, 0, 0, 0, 16'h6000, 16'hABCD, 2'b11);
        ext_stall = 1;
        wait_done(s);
        repeat (3) begin
            @(negedge clk); #1;
            chk("held_mem_stall", 16'(mem_stall), 16'h0);
            chk("held_done", 16'(dut.done), 16'h1);
            chk("held_no_write", 16'(bus.dmem_write), 16'h0);
            @(posedge clk); #1;
        end
        ext_stall = 0;
        @(negedge clk); #1;
        chk("release_mem_stall", 16'(mem_stall), 16'h0);
        @(posedge clk); #1;
        idle_inputs();
        chk("done_cleared", 16'(dut.done), 16'h0);
        chk("str_write_count", 16'(wr_cnt - w0), 16'd1);
        lat = 5;
        op(1, 0, 1, 0, 0, 16'h7000, 16'h0, 2'b11);
        @(negedge clk);
        @(negedge clk); #2;
        chk("ind_rd_active", 16'(bus.dmem_read), 16'h1);
        rst_n = 0;
        #1;
        chk("rst_dmem_read", 16'(bus.dmem_read), 16'h0);
        chk("rst_dmem_address", bus.dmem_address, 16'h0);
        chk("rst_byte_enable", 16'(bus.dmem_byte_enable), 16'h0);
        chk("rst_mem_stall", 16'(mem_stall), 16'h0);
        chk("rst_mem_rdata", mem_rdata, 16'h0);
        @(negedge clk);
        rst_n = 1;
        push(1, 0, 1, 0, 16'h7000, 2'b11, 16'h0, 16'h0);
        push(1, 0, 0, 1, 16'h8000, 2'b11, 16'h0, 16'h1111);
        wait_done(s);
        idle_inputs();
        @(negedge clk); #1;
        chk("queue_empty", 16'(q.size()), 16'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mem_stage_access_unit.md
# mem_stage_access_unit

MEM-stage data-memory sequencer that consumes the EX/MEM pipeline register outputs and drives the data-cache port. It performs word and byte loads and stores, as well as the two-access LDI/STI indirect sequences. It produces load data for the MEM/WB register and a `mem_stall` request that the top level ORs into the global `stall_pipeline`. A completed access is never replayed while the EX/MEM register is held by a stall from another source.

## Interface
- No parameters. All data widths are fixed at `lc3b_word` (16 bits).
- `clk`  in  1  — pipeline clock.
- `rst_n`  in  1  — asynchronous, active-low reset.
- `mem_read`  in  1  — EX/MEM load request (LDR, LDB, LDI).
- `mem_write`  in  1  — EX/MEM store request (STR, STB, STI).
- `is_ldi`, `is_sti`  in  1 each  — indirect access; the first access is a pointer read.
- `is_ldb_stb`  in  1  — byte access.
- `addr`  in  16  — EX/MEM address (`addr_adder_out` / `alu_out` after the address mux).
- `wdata`  in  16  — store data (`dest_data`).
- `mem_byte_enable`  in  2  — byte enables for the final access.
- `ext_stall`  in  1  — stall from any source other than this block, such as an I-cache miss.
- `dmem_rdata`  in  16  — data-cache read data.
- `dmem_resp`  in  1  — data-cache single-cycle completion pulse.
- `dmem_read`, `dmem_write`  out  1 each  — data-cache strobes.
- `dmem_address`  out  16  — data-cache address.
- `dmem_wdata`  out  16  — data-cache write data.
- `dmem_byte_enable`  out  2  — data-cache byte enables.
- `mem_rdata`  out  16  — load result to MEM/WB.
- `mem_stall`  out  1  — request to hold the pipeline.

## Operation
- `req = mem_read | mem_write`.
- If `mem_read` and `mem_write` are both 1, the block performs a read and ignores the write.
- States: IDLE, IND_RD, ACCESS.
- Internal registers:
  - `ptr[15:0]` — indirect pointer.
  - `rdata_q[15:0]` — last load result.
  - `done` — the current EX/MEM instruction is already serviced.
- IDLE:
  - If `req & ~done`: `mem_stall=1`. Next state is IND_RD if `is_ldi|is_sti`, else ACCESS.
  - No dmem strobes are asserted in IDLE.
- IND_RD:
  - Drive `dmem_read=1`, `dmem_address={addr[15:1],1'b0}`, `dmem_byte_enable=2'b11`.
  - `mem_stall=1`.
  - On `dmem_resp`: `ptr<=dmem_rdata`, go to ACCESS.
- ACCESS:
  - Address: `ea = (is_ldi|is_sti) ? ptr : addr`.
  - Strobes: `dmem_read=mem_read`, `dmem_write=mem_write&~mem_read`.
  - Word access: `dmem_address={ea[15:1],0}`, `dmem_byte_enable=mem_byte_enable`, `dmem_wdata=wdata`.
  - Byte access:
    - `dmem_address=ea` with bit 0 forced to 0.
    - `dmem_byte_enable = ea[0] ? 2'b10 : 2'b01`.
    - `dmem_wdata={wdata[7:0],wdata[7:0]}`.
  - `mem_stall = ~dmem_resp`.
  - On `dmem_resp`, go to IDLE. If a read, `rdata_q<=ld_val` and `mem_rdata=ld_val` in the same cycle.
    - Byte load: `ld_val` = `{8'h00, ea[0] ? dmem_rdata[15:8] : dmem_rdata[7:0]}`.
    - Word load: `ld_val` = `dmem_rdata`.
  - If `ext_stall=1` in the completion cycle, set `done<=1`.
- `done` clears on any cycle with `~ext_stall & ~mem_stall`, i.e. when EX/MEM advances.
- While `done=1`, IDLE ignores `req`, `mem_stall=0`, and `mem_rdata=rdata_q`.
- `mem_rdata=rdata_q` in all cycles except the ACCESS read completion cycle.

## Timing
- Reset (asynchronous on `rst_n=0`):
  - State goes to IDLE.
  - `ptr`, `rdata_q`, and `done` are cleared to 0.
  - All dmem outputs, `mem_rdata`, and `mem_stall` are 0 while in reset.
- Reset asserted mid-access aborts the access with no write retry. After `rst_n` rises, the held request restarts from IDLE.
- Latency from `req` to completion:
  - Normal access: 1 cycle in IDLE + N cycles in ACCESS, where N ≥ 1 is cache latency.
  - LDI/STI: 1 + N1 + N2 cycles.
- Minimum normal load: 2 cycles, with `mem_stall` high in cycle 1 only.
- `mem_stall` is combinational from state, `req`, `done`, and `dmem_resp`. It falls in the `dmem_resp` cycle so that EX/MEM and MEM/WB advance on that edge.
- Back-to-back memory instructions: the new request is seen in IDLE the cycle after completion. There is no bubble besides the IDLE cycle.
- dmem strobes stay asserted and stable until `dmem_resp`. `addr` and `wdata` are held stable by the stall.
- `dmem_resp` is ignored in IDLE.

## Test plan
- **LDR.** Apply LDR `addr=0x1004`, cache returns `0xBEEF` after 2 cycles. Required: `mem_stall` high 3 cycles, `dmem_address=0x1004`, BE=11, `mem_rdata=0xBEEF` in the response cycle and held afterwards.
- **LDB.** Apply LDB `addr=0x2001`, rdata `0x7A55`. Required: BE=10, `mem_rdata=0x007A`. Repeat with `addr=0x2000`: required `0x0055`.
- **STB.** Apply STB `addr=0x3003`, `wdata=0x12C4`. Required: `dmem_write=1`, address `0x3002`, BE=10, `dmem_wdata=0xC4C4`.
- **LDI.** Apply LDI `addr=0x4000`; pointer read returns `0x5000`, then `0x5000` returns `0x0042`. Required: two reads in order, `mem_rdata=0x0042`, no `dmem_write`. STI at the same addresses: one read, then a write to `0x5000`.
- **ext_stall held.** Hold `ext_stall=1` for 4 cycles across an STR completion. Required: exactly one `dmem_write` pulse sequence, `done=1`, and `mem_stall=0` while held.
- **Reset mid-access.** Pull `rst_n` low during IND_RD. Required: all outputs 0 immediately. After release the LDI restarts with a pointer read to `addr`.
